// File: rtl/counter_ir_core.sv
// counter_ir_core: two-channel edge-count / period-capture counter fed by the IR frontend
module counter_ir_core #(
    parameter int CNT_W       = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_ir_extern_din_a,
    input  logic             i_ir_extern_din_b,
    input  logic [1:0]       i_cnt_en,
    input  logic [1:0]       i_cnt_mode,
    input  logic [CNT_W-1:0] i_cmp_value_a,
    input  logic [CNT_W-1:0] i_cmp_value_b,
    input  logic [1:0]       i_ovf_clr,
    output logic             o_extern_dout_a,
    output logic             o_extern_dout_b,
    output logic [CNT_W-1:0] o_cap_value_a,
    output logic [CNT_W-1:0] o_cap_value_b,
    output logic [1:0]       o_cap_valid,
    output logic [1:0]       o_ovf
);
    typedef enum logic [1:0] {IDLE, WAIT_EDGE, RUN} state_t;

    logic [1:0]       din, dout, cap_valid, ovf;
    logic [CNT_W-1:0] cmp [2];
    logic [CNT_W-1:0] cap [2];

    assign din    = {i_ir_extern_din_b, i_ir_extern_din_a};
    assign cmp[0] = i_cmp_value_a;
    assign cmp[1] = i_cmp_value_b;

    for (genvar g = 0; g < 2; g++) begin : g_ch
        logic             sync, prev_q, rise, en, edge_hit;
        logic             mode_q, mode_d, dout_q, dout_d, cap_valid_q, cap_valid_d, ovf_q, ovf_d;
        logic [CNT_W-1:0] cnt_q, cnt_d, cap_q, cap_d, cnt_sat, cmp_eff;
        logic [CNT_W:0]   inc;
        state_t           state_q, state_d;

        if (SYNC_STAGES == 0) begin : g_nosync
            assign sync = din[g];
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] sync_q;
            always_ff @(posedge i_clk or negedge i_rst_n)
                if (!i_rst_n) sync_q <= '0;
                else          sync_q <= (sync_q << 1) | SYNC_STAGES'(din[g]);
            assign sync = sync_q[SYNC_STAGES-1];
        end

        assign en       = i_cnt_en[g];
        assign rise     = sync & ~prev_q;
        assign inc      = {1'b0, cnt_q} + 1'b1;
        assign cnt_sat  = (cnt_q == '1) ? cnt_q : inc[CNT_W-1:0];
        // A zero compare value behaves as one in edge mode: every edge pulses
        assign cmp_eff  = (cmp[g] == '0) ? CNT_W'(1) : cmp[g];
        assign edge_hit = inc >= {1'b0, cmp_eff};

        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                state_q     <= IDLE;
                prev_q      <= 1'b0;
                mode_q      <= 1'b0;
                cnt_q       <= '0;
                cap_q       <= '0;
                dout_q      <= 1'b0;
                cap_valid_q <= 1'b0;
                ovf_q       <= 1'b0;
            end else begin
                state_q     <= state_d;
                prev_q      <= sync;
                mode_q      <= mode_d;
                cnt_q       <= cnt_d;
                cap_q       <= cap_d;
                dout_q      <= dout_d;
                cap_valid_q <= cap_valid_d;
                ovf_q       <= ovf_d;
            end
        end

        always_comb
            state_d = !en                   ? IDLE
                    : (state_q == IDLE)      ? (i_cnt_mode[g] ? WAIT_EDGE : RUN)
                    : (state_q == WAIT_EDGE) ? (rise ? RUN : WAIT_EDGE)
                    : (state_q == RUN)       ? RUN
                    :                          IDLE;

        always_comb begin
            mode_d      = mode_q;
            cnt_d       = '0;
            cap_d       = cap_q;
            dout_d      = 1'b0;
            cap_valid_d = 1'b0;
            ovf_d       = ovf_q & ~i_ovf_clr[g];
            if (en && state_q == IDLE) begin
                mode_d = i_cnt_mode[g];
            end else if (en && state_q == WAIT_EDGE) begin
                cnt_d = rise ? CNT_W'(1) : '0;
            end else if (en && state_q == RUN && !mode_q) begin
                cnt_d  = !rise ? cnt_q : edge_hit ? '0 : inc[CNT_W-1:0];
                dout_d = rise & edge_hit;
            end else if (en && state_q == RUN) begin
                cnt_d       = rise ? CNT_W'(1) : cnt_sat;
                cap_d       = rise ? cnt_q : cap_q;
                cap_valid_d = rise;
                dout_d      = !rise && cmp[g] != '0 && cnt_sat >= cmp[g];
                // Saturation outranks a simultaneous clear
                ovf_d       = ovf_d | (!rise && cnt_sat == '1);
            end
        end

        assign dout[g]      = dout_q;
        assign cap[g]       = cap_q;
        assign cap_valid[g] = cap_valid_q;
        assign ovf[g]       = ovf_q;
    end

    assign o_extern_dout_a = dout[0];
    assign o_extern_dout_b = dout[1];
    assign o_cap_value_a   = cap[0];
    assign o_cap_value_b   = cap[1];
    assign o_cap_valid     = cap_valid;
    assign o_ovf           = ovf;
endmodule

// File: tb/tb_counter_ir_core.sv
// tb_counter_ir_core: queue-based scoreboard bench for counter_ir_core, plus a 4-bit instance for saturation
module tb_counter_ir_core;
    localparam int L = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        din_a, din_b;
    logic [1:0]  en, mode, clr;
    logic [31:0] cmp_a, cmp_b;
    logic        dout_a, dout_b;
    logic [31:0] cap_a, cap_b;
    logic [1:0]  capv, ovf;

    logic        din4;
    logic [1:0]  en4, mode4, clr4;
    logic        dout4a, dout4b;
    logic [3:0]  cap4a, cap4b;
    logic [1:0]  capv4, ovf4;

    typedef struct {int cyc; logic [31:0] val;} exp_t;
    exp_t q_da[$], q_db[$], q_ca[$], q_cb[$], q_c4[$];
    int cyc = 0, checks = 0, errors = 0;
    logic prev_a = 1'b0, prev_b = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    counter_ir_core #(.CNT_W(32), .SYNC_STAGES(2)) u_dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_ir_extern_din_a(din_a), .i_ir_extern_din_b(din_b),
        .i_cnt_en(en), .i_cnt_mode(mode),
        .i_cmp_value_a(cmp_a), .i_cmp_value_b(cmp_b),
        .i_ovf_clr(clr),
        .o_extern_dout_a(dout_a), .o_extern_dout_b(dout_b),
        .o_cap_value_a(cap_a), .o_cap_value_b(cap_b),
        .o_cap_valid(capv), .o_ovf(ovf)
    );

    counter_ir_core #(.CNT_W(4), .SYNC_STAGES(2)) u_dut4 (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_ir_extern_din_a(din4), .i_ir_extern_din_b(1'b0),
        .i_cnt_en(en4), .i_cnt_mode(mode4),
        .i_cmp_value_a(4'd0), .i_cmp_value_b(4'd0),
        .i_ovf_clr(clr4),
        .o_extern_dout_a(dout4a), .o_extern_dout_b(dout4b),
        .o_cap_value_a(cap4a), .o_cap_value_b(cap4b),
        .o_cap_valid(capv4), .o_ovf(ovf4)
    );

    task automatic chk(input string nm, input bit ok, input longint act, input longint req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [1:0] m, input int gap);
        din_a = m[0];
        din_b = m[1];
        step(1);
        din_a = 1'b0;
        din_b = 1'b0;
        step(gap - 1);
    endtask

    // Monitor: every output transition / capture strobe consumes one expectation
    always @(negedge clk) begin
        exp_t e;
        if (dout_a !== prev_a) begin
            if (q_da.size() == 0) chk("dout_a unexpected transition", 1'b0, dout_a, prev_a);
            else begin
                e = q_da.pop_front();
                chk("dout_a cycle", cyc == e.cyc, cyc, e.cyc);
                chk("dout_a level", dout_a === e.val[0], dout_a, e.val);
            end
        end
        if (dout_b !== prev_b) begin
            if (q_db.size() == 0) chk("dout_b unexpected transition", 1'b0, dout_b, prev_b);
            else begin
                e = q_db.pop_front();
                chk("dout_b cycle", cyc == e.cyc, cyc, e.cyc);
                chk("dout_b level", dout_b === e.val[0], dout_b, e.val);
            end
        end
        if (capv[0] === 1'b1) begin
            if (q_ca.size() == 0) chk("cap_a unexpected valid", 1'b0, cap_a, 0);
            else begin
                e = q_ca.pop_front();
                chk("cap_a cycle", cyc == e.cyc, cyc, e.cyc);
                chk("cap_a value", cap_a === e.val, cap_a, e.val);
            end
        end
        if (capv[1] === 1'b1) begin
            if (q_cb.size() == 0) chk("cap_b unexpected valid", 1'b0, cap_b, 0);
            else begin
                e = q_cb.pop_front();
                chk("cap_b cycle", cyc == e.cyc, cyc, e.cyc);
                chk("cap_b value", cap_b === e.val, cap_b, e.val);
            end
        end
        if (capv4[0] === 1'b1) begin
            if (q_c4.size() == 0) chk("cap4 unexpected valid", 1'b0, cap4a, 0);
            else begin
                e = q_c4.pop_front();
                chk("cap4 cycle", cyc == e.cyc, cyc, e.cyc);
                chk("cap4 value", {28'd0, cap4a} === e.val, cap4a, e.val);
            end
        end
        prev_a = dout_a;
        prev_b = dout_b;
    end

    initial begin
        rst_n = 1'b0;
        {din_a, din_b, din4} = '0;
        {en, mode, clr, en4, mode4, clr4} = '0;
        cmp_a = '0;
        cmp_b = '0;
        step(2);
        chk("reset dout_a", dout_a === 1'b0, dout_a, 0);
        chk("reset dout_b", dout_b === 1'b0, dout_b, 0);
        chk("reset cap_a", cap_a === '0, cap_a, 0);
        chk("reset cap_b", cap_b === '0, cap_b, 0);
        chk("reset cap_valid", capv === 2'b00, capv, 0);
        chk("reset ovf", ovf === 2'b00, ovf, 0);
        rst_n = 1'b1;
        step(2);

        // Edge mode A, cmp=3: pulse on edges 3 and 6, one clock wide
        cmp_a = 3; mode[0] = 1'b0; en[0] = 1'b1;
        step(2);
        for (int k = 1; k <= 7; k++) begin
            if (k == 3 || k == 6) begin
                q_da.push_back('{cyc + L, 1});
                q_da.push_back('{cyc + L + 1, 0});
            end
            pulse(2'b01, 4);
        end
        en[0] = 1'b0;
        step(2);

        // Period mode B, 10-clock spacing, timeout disabled
        cmp_b = 0; mode[1] = 1'b1; en[1] = 1'b1;
        step(2);
        pulse(2'b10, 10);
        for (int k = 1; k <= 3; k++) begin
            q_cb.push_back('{cyc + L, 10});
            pulse(2'b10, 10);
        end
        chk("cap_b held", cap_b === 32'd10, cap_b, 10);
        en[1] = 1'b0;
        step(2);

        // Period mode A, cmp=5, 8-clock spacing: timeout level from count 5 until next edge
        cmp_a = 5; mode[0] = 1'b1; en[0] = 1'b1;
        step(2);
        q_da.push_back('{cyc + 7, 1});
        pulse(2'b01, 8);
        for (int k = 0; k < 2; k++) begin
            q_da.push_back('{cyc + L, 0});
            q_ca.push_back('{cyc + L, 8});
            q_da.push_back('{cyc + 7, 1});
            pulse(2'b01, 8);
        end
        q_da.push_back('{cyc + 1, 0});
        en[0] = 1'b0;
        step(2);

        // Mode change while enabled is ignored; re-enable restarts count and applies new mode
        cmp_a = 3; mode[0] = 1'b0; en[0] = 1'b1;
        step(2);
        pulse(2'b01, 4);
        pulse(2'b01, 4);
        mode[0] = 1'b1;
        q_da.push_back('{cyc + L, 1});
        q_da.push_back('{cyc + L + 1, 0});
        pulse(2'b01, 4);
        pulse(2'b01, 4);
        pulse(2'b01, 4);
        en[0] = 1'b0;
        step(2);
        chk("dout_a after disable", dout_a === 1'b0, dout_a, 0);
        chk("cap_a retained over disable", cap_a === 32'd8, cap_a, 8);
        mode[0] = 1'b0; en[0] = 1'b1;
        step(2);
        pulse(2'b01, 4);
        pulse(2'b01, 4);
        q_da.push_back('{cyc + L, 1});
        q_da.push_back('{cyc + L + 1, 0});
        pulse(2'b01, 4);
        en[0] = 1'b0;
        step(2);
        cmp_a = 0; mode[0] = 1'b1; en[0] = 1'b1;
        step(2);
        chk("cap_a retained into period mode", cap_a === 32'd8, cap_a, 8);
        pulse(2'b01, 6);
        q_ca.push_back('{cyc + L, 6});
        pulse(2'b01, 6);
        en[0] = 1'b0;
        step(2);

        // 4-bit counter saturation, ovf set wins over simultaneous clear
        mode4 = 2'b01; en4 = 2'b01;
        step(2);
        chk("ovf4 idle", ovf4[0] === 1'b0, ovf4[0], 0);
        din4 = 1'b1;
        step(1);
        din4 = 1'b0;
        step(15);
        chk("ovf4 before saturation", ovf4[0] === 1'b0, ovf4[0], 0);
        clr4 = 2'b01;
        step(1);
        clr4 = 2'b00;
        chk("ovf4 set beats clr", ovf4[0] === 1'b1, ovf4[0], 1);
        step(5);
        q_c4.push_back('{cyc + L, 15});
        din4 = 1'b1;
        step(1);
        din4 = 1'b0;
        step(4);
        chk("ovf4 sticky after capture", ovf4[0] === 1'b1, ovf4[0], 1);
        chk("cap4 saturated", cap4a === 4'hF, cap4a, 15);
        clr4 = 2'b01;
        step(1);
        clr4 = 2'b00;
        chk("ovf4 cleared", ovf4[0] === 1'b0, ovf4[0], 0);
        en4 = 2'b00;
        step(2);

        // cmp=0 on both channels, then async reset mid-run
        cmp_a = 0; cmp_b = 0; mode = 2'b10; en = 2'b11;
        step(2);
        for (int k = 0; k < 3; k++) begin
            q_da.push_back('{cyc + L, 1});
            q_da.push_back('{cyc + L + 1, 0});
            if (k > 0) q_cb.push_back('{cyc + L, 10});
            pulse(2'b11, 10);
        end
        din_a = 1'b1;
        step(1);
        din_a = 1'b0;
        step(2);
        chk("dout_a high before reset", dout_a === 1'b1, dout_a, 1);
        chk("cap_b before reset", cap_b === 32'd10, cap_b, 10);
        rst_n = 1'b0;
        #2;
        chk("async reset dout_a", dout_a === 1'b0, dout_a, 0);
        chk("async reset dout_b", dout_b === 1'b0, dout_b, 0);
        chk("async reset cap_a", cap_a === '0, cap_a, 0);
        chk("async reset cap_b", cap_b === '0, cap_b, 0);
        chk("async reset cap_valid", capv === 2'b00, capv, 0);
        chk("async reset ovf", ovf === 2'b00, ovf, 0);
        en = 2'b00;
        step(2);
        rst_n = 1'b1;
        step(2);
        mode[0] = 1'b0; en[0] = 1'b1;
        step(2);
        q_da.push_back('{cyc + L, 1});
        q_da.push_back('{cyc + L + 1, 0});
        pulse(2'b01, 4);
        en[0] = 1'b0;
        step(5);
        chk("cap_b after reset", cap_b === '0, cap_b, 0);

        chk("dout_a events drained", q_da.size() == 0, q_da.size(), 0);
        chk("dout_b events drained", q_db.size() == 0, q_db.size(), 0);
        chk("cap_a events drained", q_ca.size() == 0, q_ca.size(), 0);
        chk("cap_b events drained", q_cb.size() == 0, q_cb.size(), 0);
        chk("cap4 events drained", q_c4.size() == 0, q_c4.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
